// File: rtl/custom_busmatrix_qos_arbiter.sv
// rtl/custom_busmatrix_qos_arbiter.sv - three-port AHB bus-matrix arbiter with priority, aging and burst/lock hold
module custom_busmatrix_qos_arbiter #(
   parameter int AGE_LIMIT       = 15,
   parameter int INCR_HOLD_BEATS = 4
) (
   input  logic       HCLK,
   input  logic       HRESET,
   input  logic       req_port0,
   input  logic       req_port1,
   input  logic       req_port2,
   input  logic [1:0] prio_port0,
   input  logic [1:0] prio_port1,
   input  logic [1:0] prio_port2,
   input  logic       HREADYM,
   input  logic       HSELM,
   input  logic [1:0] HTRANSM,
   input  logic [2:0] HBURSTM,
   input  logic       HMASTLOCKM,
   output logic [1:0] addr_in_port,
   output logic       no_port,
   output logic       grant_change
);

   localparam logic [3:0] AGE_MAX  = 4'(AGE_LIMIT);
   localparam logic [3:0] INCR_REM = 4'(INCR_HOLD_BEATS - 1);

   localparam logic [1:0] TR_IDLE   = 2'b00;
   localparam logic [1:0] TR_NONSEQ = 2'b10;
   localparam logic [1:0] TR_SEQ    = 2'b11;

   logic [3:0] remain;
   logic [3:0] next_remain;
   logic       hold;
   logic [2:0] req;
   logic [1:0] prio     [3];
   logic [2:0] eff      [3];
   logic [3:0] age      [3];
   logic [3:0] age_nxt  [3];
   logic [1:0] ord      [3];
   logic       found;
   logic [1:0] win;
   logic [2:0] best;
   logic [1:0] nxt_addr;
   logic       nxt_none;

   assign req     = {req_port2, req_port1, req_port0};
   assign prio[0] = prio_port0;
   assign prio[1] = prio_port1;
   assign prio[2] = prio_port2;

   function automatic logic [1:0] next_port(input logic [1:0] p);
      return (p == 2'd2) ? 2'd0 : p + 2'd1;
   endfunction

   // Beats still owed by the current burst after this transfer completes
   always_comb begin
      next_remain = remain;
      if (!HSELM || HTRANSM == TR_IDLE) begin
         next_remain = 4'd0;
      end else if (HTRANSM == TR_NONSEQ) begin
         case (HBURSTM)
            3'b000:         next_remain = 4'd0;
            3'b001:         next_remain = INCR_REM;
            3'b010, 3'b011: next_remain = 4'd3;
            3'b100, 3'b101: next_remain = 4'd7;
            default:        next_remain = 4'd15;
         endcase
      end else if (HTRANSM == TR_SEQ) begin
         next_remain = (remain != 4'd0) ? remain - 4'd1 : 4'd0;
      end
   end

   assign hold = (next_remain != 4'd0) | HMASTLOCKM;

   // Effective priority, round-robin search order and next grant decision
   always_comb begin
      for (int n = 0; n < 3; n++) begin
         eff[n] = (age[n] == AGE_MAX) ? 3'd4 : {1'b0, prio[n]};
      end
      ord[0] = no_port ? 2'd0 : next_port(addr_in_port);
      ord[1] = next_port(ord[0]);
      ord[2] = next_port(ord[1]);
      found  = 1'b0;
      win    = 2'd0;
      best   = 3'd0;
      for (int k = 0; k < 3; k++) begin
         if (req[ord[k]] && (!found || eff[ord[k]] > best)) begin
            found = 1'b1;
            best  = eff[ord[k]];
            win   = ord[k];
         end
      end
      nxt_addr = addr_in_port;
      nxt_none = no_port;
      if (!hold) begin
         if (found) begin
            nxt_addr = win;
            nxt_none = 1'b0;
         end else if (no_port || !HSELM) begin
            nxt_none = 1'b1;
         end
      end
      for (int n = 0; n < 3; n++) begin
         if (!req[n] || (!nxt_none && nxt_addr == 2'(n))) begin
            age_nxt[n] = 4'd0;
         end else if (age[n] == AGE_MAX) begin
            age_nxt[n] = age[n];
         end else begin
            age_nxt[n] = age[n] + 4'd1;
         end
      end
   end

   // State advances only on completed transfers; the change pulse is refreshed every edge
   always_ff @(posedge HCLK) begin
      if (HRESET) begin
         addr_in_port <= 2'd0;
         no_port      <= 1'b1;
         grant_change <= 1'b0;
         remain       <= 4'd0;
         for (int n = 0; n < 3; n++) age[n] <= 4'd0;
      end else begin
         grant_change <= HREADYM & ({nxt_none, nxt_addr} != {no_port, addr_in_port});
         if (HREADYM) begin
            addr_in_port <= nxt_addr;
            no_port      <= nxt_none;
            remain       <= next_remain;
            for (int n = 0; n < 3; n++) age[n] <= age_nxt[n];
         end
      end
   end

endmodule

// File: tb/tb_custom_busmatrix_qos_arbiter.sv
// tb/tb_custom_busmatrix_qos_arbiter.sv - scoreboard bench for custom_busmatrix_qos_arbiter
module tb_custom_busmatrix_qos_arbiter;

   localparam int AGE  = 3;
   localparam int INCR = 6;

   logic       HCLK = 1'b0;
   logic       HRESET;
   logic       req [3];
   logic [1:0] prio [3];
   logic       HREADYM;
   logic       HSELM;
   logic [1:0] HTRANSM;
   logic [2:0] HBURSTM;
   logic       HMASTLOCKM;
   logic [1:0] addr_in_port;
   logic       no_port;
   logic       grant_change;

   int checks = 0;
   int errors = 0;

   typedef struct {
      int addr;
      int none;
      int gc;
   } exp_t;
   exp_t sbq[$];

   int m_addr;
   int m_none;
   int m_gc;
   int m_remain;
   int m_age [3];

   custom_busmatrix_qos_arbiter #(
      .AGE_LIMIT(AGE),
      .INCR_HOLD_BEATS(INCR)
   ) dut (
      .HCLK(HCLK),
      .HRESET(HRESET),
      .req_port0(req[0]),
      .req_port1(req[1]),
      .req_port2(req[2]),
      .prio_port0(prio[0]),
      .prio_port1(prio[1]),
      .prio_port2(prio[2]),
      .HREADYM(HREADYM),
      .HSELM(HSELM),
      .HTRANSM(HTRANSM),
      .HBURSTM(HBURSTM),
      .HMASTLOCKM(HMASTLOCKM),
      .addr_in_port(addr_in_port),
      .no_port(no_port),
      .grant_change(grant_change)
   );

   always #5 HCLK = ~HCLK;

   function automatic int burst_beats(input logic [2:0] b);
      case (b)
         3'd0:       return 1;
         3'd1:       return INCR;
         3'd2, 3'd3: return 4;
         3'd4, 3'd5: return 8;
         default:    return 16;
      endcase
   endfunction

   task automatic model_step();
      int  nrem, start, win, best, e, p, na, nn;
      bit  hold;
      if (HRESET) begin
         m_addr = 0; m_none = 1; m_gc = 0; m_remain = 0;
         for (int i = 0; i < 3; i++) m_age[i] = 0;
         return;
      end
      if (!HREADYM) begin
         m_gc = 0;
         return;
      end
      if (!HSELM || HTRANSM == 2'b00) nrem = 0;
      else if (HTRANSM == 2'b10)      nrem = burst_beats(HBURSTM) - 1;
      else if (HTRANSM == 2'b11)      nrem = (m_remain > 0) ? m_remain - 1 : 0;
      else                            nrem = m_remain;
      hold = (nrem != 0) || HMASTLOCKM;
      na = m_addr;
      nn = m_none;
      if (!hold) begin
         start = m_none ? 0 : (m_addr + 1) % 3;
         win = -1;
         best = -1;
         for (int k = 0; k < 3; k++) begin
            p = (start + k) % 3;
            if (req[p]) begin
               e = (m_age[p] == AGE) ? 4 : int'(prio[p]);
               if (e > best) begin best = e; win = p; end
            end
         end
         if (win >= 0) begin na = win; nn = 0; end
         else if (m_none == 1 || !HSELM) nn = 1;
      end
      for (int i = 0; i < 3; i++) begin
         if (!req[i] || (nn == 0 && na == i)) m_age[i] = 0;
         else m_age[i] = (m_age[i] + 1 > AGE) ? AGE : m_age[i] + 1;
      end
      m_gc = (na != m_addr || nn != m_none) ? 1 : 0;
      m_addr = na;
      m_none = nn;
      m_remain = nrem;
   endtask

   task automatic cyc();
      exp_t e;
      @(negedge HCLK);
      model_step();
      e.addr = m_addr;
      e.none = m_none;
      e.gc   = m_gc;
      sbq.push_back(e);
      @(posedge HCLK);
      #2;
   endtask

   task automatic chk(input string nm, input int a, input int n, input int g);
      checks++;
      if (addr_in_port !== 2'(a) || no_port !== n[0] || grant_change !== g[0]) begin
         errors++;
         $display("FAIL %s: got addr=%0d none=%0d gc=%0d want addr=%0d none=%0d gc=%0d",
                  nm, addr_in_port, no_port, grant_change, a, n, g);
      end
   endtask

   task automatic set_idle();
      HRESET = 1'b0; HREADYM = 1'b1; HSELM = 1'b1; HTRANSM = 2'b00;
      HBURSTM = 3'b000; HMASTLOCKM = 1'b0;
      for (int i = 0; i < 3; i++) begin req[i] = 1'b0; prio[i] = 2'd0; end
   endtask

   task automatic do_reset();
      set_idle();
      HRESET = 1'b1;
      cyc();
      HRESET = 1'b0;
   endtask

   // Scoreboard monitor: every edge presents a decision to compare
   initial begin
      exp_t e;
      forever begin
         @(posedge HCLK);
         #1;
         if (sbq.size() > 0) begin
            e = sbq.pop_front();
            checks++;
            if (addr_in_port !== 2'(e.addr) || no_port !== e.none[0] || grant_change !== e.gc[0]) begin
               errors++;
               $display("FAIL sb @%0t: got addr=%0d none=%0d gc=%0d want addr=%0d none=%0d gc=%0d",
                        $time, addr_in_port, no_port, grant_change, e.addr, e.none, e.gc);
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout want finish");
      $fatal(1);
   end

   initial begin
      int rr [6];
      int ag [5];
      int ag_gc [5];
      rr = '{0, 1, 2, 0, 1, 2};
      ag = '{0, 0, 0, 1, 0};
      ag_gc = '{1, 0, 0, 1, 1};

      set_idle();
      HRESET = 1'b1;
      cyc();
      cyc();
      chk("reset", 0, 1, 0);

      // Priority
      HRESET = 1'b0;
      req[1] = 1'b1; prio[1] = 2'd1;
      req[2] = 1'b1; prio[2] = 2'd3;
      cyc();
      chk("prio_grant", 2, 0, 1);
      cyc();
      chk("prio_keep", 2, 0, 0);

      // Burst hold: INCR4 owned by port0 while port1 waits
      do_reset();
      req[0] = 1'b1;
      cyc();
      chk("burst_first", 0, 0, 1);
      req[1] = 1'b1;
      HTRANSM = 2'b10; HBURSTM = 3'b011;
      cyc();
      chk("burst_nonseq", 0, 0, 0);
      HTRANSM = 2'b11;
      cyc();
      chk("burst_seq1", 0, 0, 0);
      cyc();
      chk("burst_seq2", 0, 0, 0);
      cyc();
      chk("burst_seq3", 1, 0, 1);

      // Aging: low-priority port1 boosted on 4th arbitration
      do_reset();
      req[0] = 1'b1; prio[0] = 2'd3;
      req[1] = 1'b1; prio[1] = 2'd0;
      HTRANSM = 2'b10; HBURSTM = 3'b000;
      for (int i = 0; i < 5; i++) begin
         cyc();
         chk($sformatf("aging_%0d", i), ag[i], 0, ag_gc[i]);
      end

      // Round-robin among equal priorities
      do_reset();
      for (int i = 0; i < 3; i++) begin req[i] = 1'b1; prio[i] = 2'd2; end
      HTRANSM = 2'b10; HBURSTM = 3'b000;
      for (int i = 0; i < 6; i++) begin
         cyc();
         chk($sformatf("rr_%0d", i), rr[i], 0, 1);
      end

      // Lock then reset
      do_reset();
      req[2] = 1'b1;
      cyc();
      chk("lock_grant", 2, 0, 1);
      HMASTLOCKM = 1'b1; req[0] = 1'b1; prio[0] = 2'd3;
      HTRANSM = 2'b10;
      for (int i = 0; i < 4; i++) begin
         cyc();
         chk($sformatf("lock_hold_%0d", i), 2, 0, 0);
      end
      HRESET = 1'b1;
      cyc();
      chk("lock_reset", 0, 1, 0);
      HRESET = 1'b0; HMASTLOCKM = 1'b0; req[2] = 1'b0; HTRANSM = 2'b00;
      cyc();
      chk("lock_after", 0, 0, 1);

      // Stall with new requests pending
      HREADYM = 1'b0;
      req[1] = 1'b1; prio[1] = 2'd3;
      req[2] = 1'b1; prio[2] = 2'd3;
      prio[0] = 2'd0;
      for (int i = 0; i < 5; i++) begin
         cyc();
         chk($sformatf("stall_%0d", i), 0, 0, 0);
      end
      HREADYM = 1'b1;
      cyc();
      chk("stall_release", 1, 0, 1);

      // Randomized traffic against the reference model
      for (int i = 0; i < 600; i++) begin
         HRESET     = ($urandom_range(0, 39) == 0);
         HREADYM    = ($urandom_range(0, 3) != 0);
         HSELM      = ($urandom_range(0, 7) != 0);
         HTRANSM    = 2'($urandom_range(0, 3));
         HBURSTM    = 3'($urandom_range(0, 7));
         HMASTLOCKM = ($urandom_range(0, 9) == 0);
         for (int p = 0; p < 3; p++) begin
            req[p]  = ($urandom_range(0, 2) != 0);
            prio[p] = 2'($urandom_range(0, 3));
         end
         cyc();
      end

      set_idle();
      cyc();
      @(posedge HCLK);
      #3;
      checks++;
      if (sbq.size() != 0) begin
         errors++;
         $display("FAIL sb_drain: got %0d pending want 0", sbq.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/custom_busmatrix_qos_arbiter.md
CUSTOM_BUSMATRIX_QOS_ARBITER -- requirements
Module: custom_BusMatrixQosArbiter

Interface
REQ-001 The block SHALL have parameter AGE_LIMIT, default 15, range 1..15: the wait count (in HREADYM cycles) after which a requesting port is boosted.
REQ-002 The block SHALL have parameter INCR_HOLD_BEATS, default 4, range 1..16: the beats for which an undefined-length INCR burst holds arbitration.
REQ-003 HCLK  input  1  AHB system clock; the block SHALL use this single clock only, with all state updated on its rising edge.
REQ-004 HRESET  input  1  reset; the block SHALL treat it as synchronous and active-high.
REQ-005 req_port0/1/2  input  1 each  request from input port 0/1/2.
REQ-006 prio_port0/1/2  input  2 each  static priority of input port 0/1/2; 3 is the highest.
REQ-007 HREADYM  input  1  transfer done on the shared output.
REQ-008 HSELM  input  1  slave select on the shared output.
REQ-009 HTRANSM  input  2  transfer type: IDLE=00, BUSY=01, NONSEQ=10, SEQ=11.
REQ-010 HBURSTM  input  3  burst type, standard AHB encoding.
REQ-011 HMASTLOCKM  input  1  locked transfer.
REQ-012 addr_in_port  output  2  granted port (0..2).
REQ-013 no_port  output  1  no port is granted.
REQ-014 grant_change  output  1  one-cycle pulse when the grant changes.

Function
REQ-015 All registered state SHALL update only on HCLK edges where HREADYM=1, except grant_change, which SHALL update on every edge.
REQ-016 Burst counter remain (4 bits) SHALL follow these rules, in order:
- ~HSELM or IDLE -> 0.
- NONSEQ: 15 for INCR16/WRAP16, 7 for INCR8/WRAP8, 3 for INCR4/WRAP4, INCR_HOLD_BEATS-1 for INCR, 0 for SINGLE.
- SEQ: remain-1 if nonzero, else 0.
- BUSY: unchanged.
REQ-017 The combinational next-remain SHALL be used to derive hold = (next_remain != 0) | HMASTLOCKM.
REQ-018 While hold=1, addr_in_port and no_port SHALL keep their values.
REQ-019 Each port's wait counter age_N (4 bits) SHALL behave as follows on each HREADYM cycle:
- 0 if req_portN=0.
- 0 if port N is the next grantee.
- Otherwise +1, saturating at AGE_LIMIT.
REQ-020 A port's effective priority SHALL be 4 when age_N == AGE_LIMIT, and prio_portN otherwise.
REQ-021 When not holding, the arbiter SHALL grant the requesting port with the highest effective priority.
REQ-022 Ties SHALL be broken round-robin:
- Search order starts at the port after the current addr_in_port (0->1->2->0).
- When no_port=1, search order starts at port 0.
REQ-023 When not holding and no port is requesting, the grant SHALL stay the same if no_port=0 and HSELM=1; otherwise next no_port SHALL be 1 and addr_in_port SHALL be unchanged.
REQ-024 Whenever a port is granted, next no_port SHALL be 0.
REQ-025 grant_change SHALL be 1 for exactly the one cycle after an HREADYM edge in which {no_port, addr_in_port} changed, and 0 otherwise.
REQ-026 Simultaneous events:
- A port that requests and is granted in the same cycle SHALL get age reset to 0.
- A lock asserted in the same cycle as a NONSEQ SHALL hold from that cycle.
REQ-027 When HREADYM=0, the arbiter SHALL keep all decisions; requests that are still pending SHALL be re-evaluated on the next HREADYM=1 edge.
REQ-028 Port encoding 2'b11 is unreachable; the block SHALL never produce it.

Reset
REQ-029 On an HCLK edge with HRESET=1, the block SHALL set:
- addr_in_port=0, no_port=1, grant_change=0.
- remain=0.
- All age counters = 0.
REQ-030 A reset in the middle of a burst or lock SHALL abandon the hold immediately; arbitration SHALL resume from the no_port state on the first edge after HRESET falls.
REQ-031 Reset SHALL take priority over HREADYM.

Verification
REQ-032 Priority test:
- Stimulus: no_port=1; req_port1 (prio 1) and req_port2 (prio 3) both asserted; HREADYM=1.
- Required response: addr_in_port=2, no_port=0, grant_change pulses next cycle.
REQ-033 Burst hold test:
- Stimulus: port0 granted; NONSEQ INCR4 then 3 SEQ; req_port1 asserted throughout.
- Required response: grant stays 0 for 4 beats, then moves to 1 after the last SEQ.
REQ-034 Aging test:
- Stimulus: AGE_LIMIT=3; port0 (prio 3) and port1 (prio 0) requesting continuously with single transfers.
- Required response: port1 granted on the 4th arbitration, then age1 returns to 0.
REQ-035 Round-robin test:
- Stimulus: all ports prio 2, all requesting, single transfers.
- Required response: grant sequence 0,1,2,0,1,2.
REQ-036 Lock and reset test:
- Stimulus: port2 locked with HMASTLOCKM=1 and req_port0 asserted; then HRESET=1 for 1 cycle.
- Required response: grant stays 2 during the lock; after reset, addr_in_port=0 and no_port=1; next arbitration grants port0.
REQ-037 Stall test:
- Stimulus: HREADYM=0 for 5 cycles with new requests present.
- Required response: outputs and ages unchanged; grant_change=0.
